memory_handshake_unit: RTL and testbench
========================================

Name: memory_handshake_unit

Overview:
- Word-organised main-store with a request/acknowledge handshake. It sits directly downstream of the datapath and control unit.
- Consumes the address on the A bus, write data on the B bus, and the RD and WRMain strobes from control.
- Returns a read word on its data bus, which feeds the datapath memory-data input, plus a one-cycle ACK that lets control advance past memory microinstructions.
- Models configurable wait states so microcode is exercised against a multi-cycle memory.

Parameters:
- DATAWIDTH_BUS, 32, width of address, write-data and read-data buses.
- ADDR_INDEX_BITS, 10, log2 of word depth (1024 words).
- WAIT_STATES, 2, extra cycles between request acceptance and ACK (legal range 0..15).
- WAIT_CNT_WIDTH, 4, width of the wait-state counter.

Ports:
- MEMORY_HANDSHAKE_UNIT_CLOCK_50  in  1  system clock.
- MEMORY_HANDSHAKE_UNIT_ResetInHigh_In  in  1  asynchronous, active-high reset.
- MEMORY_HANDSHAKE_UNIT_A_InBus  in  DATAWIDTH_BUS  byte address.
- MEMORY_HANDSHAKE_UNIT_B_InBus  in  DATAWIDTH_BUS  write data.
- MEMORY_HANDSHAKE_UNIT_RD_In  in  1  read request.
- MEMORY_HANDSHAKE_UNIT_WRMain_In  in  1  write request.
- MEMORY_HANDSHAKE_UNIT_Data_OutBus  out  DATAWIDTH_BUS  read data.
- MEMORY_HANDSHAKE_UNIT_ACK_Out  out  1  transaction-complete pulse.
- MEMORY_HANDSHAKE_UNIT_Busy_Out  out  1  high while a transaction is in flight.

Behaviour:
- Clocking and reset:
  - Single clock, rising edge.
  - Reset is asynchronous and active-high.
  - Reset values: Data_OutBus = 0, ACK_Out = 0, Busy_Out = 0, FSM = IDLE, wait counter = 0.
  - RAM contents are not reset.
- Addressing:
  - Word index = A[ADDR_INDEX_BITS+1:2].
  - Upper address bits are ignored, so out-of-range addresses alias (wrap modulo depth).
  - A[1:0] is ignored unless the optional feature is enabled.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with RD=1 or WRMain=1, latch the word index, B data and operation type.
  - Load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, otherwise go to RESP.
  - If RD and WRMain are both 1, the operation is a read; the write is dropped.
- WAIT:
  - Busy=1; counter decrements each cycle.
  - When counter reaches 1, go to RESP on the next edge.
  - Request inputs are ignored; latched values are used.
  - Deasserting RD/WRMain mid-transaction does not abort.
- Transition into RESP:
  - Read: RAM[index] is registered onto Data_OutBus.
  - Write: RAM[index] <= latched B; Data_OutBus is unchanged.
- RESP:
  - ACK=1 and Busy=1 for exactly one cycle, then IDLE unconditionally.
  - Requests are not sampled in RESP, so a request still held high is re-accepted in the IDLE cycle after ACK.
  - Control must drop RD/WRMain on ACK.
- Latency: request sampled at edge k gives ACK high during cycle k+WAIT_STATES+1.
  - WAIT_STATES=0: ACK in the cycle after acceptance.
  - Minimum back-to-back spacing is WAIT_STATES+2 cycles.
- Data hold: Data_OutBus holds the last read word until the next read completes (writes and idle cycles do not disturb it).
- Reset mid-transaction: aborts immediately to IDLE with ACK=0. A pending write that has not reached RESP does not modify RAM.
- Read-after-write to the same address in consecutive transactions returns the new data.

Optional Feature:
- Macro: MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN.
- Defined:
  - Adds output MEMORY_HANDSHAKE_UNIT_Misalign_Out (1 bit, reset 0).
  - If A[1:0] != 0 at acceptance, the transaction still takes the normal handshake path (ACK issued), but RAM is not written and Data_OutBus is not updated.
  - Misalign_Out is high together with ACK for that one cycle.
- Undefined: no port; A[1:0] is silently ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Operation type constants (OP_READ, OP_WRITE).
  - Default ADDR_INDEX_BITS and WAIT_STATES.
- One natural sub-module, memory_handshake_ram: synchronous single-port word RAM with write enable and registered read. The FSM and counter stay in the top.

Test Plan:
- Reset mid-WAIT of a write of 0xDEADBEEF to 0x10 -> ACK never pulses; a later read of 0x10 returns the prior contents; all outputs 0 during reset.
- WAIT_STATES=2: write 0xCAFEF00D to 0x0000_0040, then read 0x40 -> each ACK is exactly 3 cycles after acceptance and 1 cycle wide; Data_OutBus=0xCAFEF00D on the read ACK.
- RD and WRMain both high at 0x80 with B=0x12345678 -> read performed; RAM[0x80] unchanged (verified by follow-up read).
- Address aliasing with ADDR_INDEX_BITS=10: write 0xA5A5A5A5 to 0x0000_1004, read 0x0000_0004 -> 0xA5A5A5A5.
- WAIT_STATES=0, RD held high continuously at 0x8 -> ACK pulses every 2 cycles; Busy toggles 1,0 pattern; data stable.
- With MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN: write to 0x0000_0042 -> ACK and Misalign_Out high in the same cycle; RAM[0x40] unchanged. Without the macro: same stimulus writes RAM[0x40].

Source files
------------

// File: rtl/memory_handshake_unit_pkg.sv
// Shared constants for the memory handshake unit: FSM encoding, operation types, default geometry.
package memory_handshake_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int unsigned DEFAULT_ADDR_INDEX_BITS = 10;
    localparam int unsigned DEFAULT_WAIT_STATES     = 2;

endpackage

// File: rtl/memory_handshake_ram.sv
// Synchronous single-port word RAM with write enable and a resettable registered read port.
module memory_handshake_ram
    import memory_handshake_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_INDEX_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds its value until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_handshake_unit.sv
// Word main-store with RD/WRMain request, configurable wait states and a one-cycle ACK.
// Optional misaligned-access trap: define MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN.
module memory_handshake_unit
    import memory_handshake_unit_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS   = 32,
    parameter int unsigned ADDR_INDEX_BITS = DEFAULT_ADDR_INDEX_BITS,
    parameter int unsigned WAIT_STATES     = DEFAULT_WAIT_STATES,
    parameter int unsigned WAIT_CNT_WIDTH  = 4
) (
    input  logic                     MEMORY_HANDSHAKE_UNIT_CLOCK_50,
    input  logic                     MEMORY_HANDSHAKE_UNIT_ResetInHigh_In,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_HANDSHAKE_UNIT_A_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_HANDSHAKE_UNIT_B_InBus,
    input  logic                     MEMORY_HANDSHAKE_UNIT_RD_In,
    input  logic                     MEMORY_HANDSHAKE_UNIT_WRMain_In,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_HANDSHAKE_UNIT_Data_OutBus,
    output logic                     MEMORY_HANDSHAKE_UNIT_ACK_Out,
    output logic                     MEMORY_HANDSHAKE_UNIT_Busy_Out
`ifdef MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN
    ,
    output logic                     MEMORY_HANDSHAKE_UNIT_Misalign_Out
`endif
);

    logic clk;
    logic rst;
    assign clk = MEMORY_HANDSHAKE_UNIT_CLOCK_50;
    assign rst = MEMORY_HANDSHAKE_UNIT_ResetInHigh_In;

    state_e                      state_q;
    logic [WAIT_CNT_WIDTH-1:0]   cnt_q;
    logic [ADDR_INDEX_BITS-1:0]  idx_q;
    logic [DATAWIDTH_BUS-1:0]    wdata_q;
    op_e                         op_q;
    logic                        ack_q;
    logic                        busy_q;

    logic                        req_c;
    op_e                         op_in_c;
    logic [ADDR_INDEX_BITS-1:0]  idx_in_c;
    logic                        direct_c;
    logic                        finish_c;
    logic                        trap_c;
    logic                        ram_en_c;
    logic                        ram_we_c;
    logic [ADDR_INDEX_BITS-1:0]  ram_addr_c;
    logic [DATAWIDTH_BUS-1:0]    ram_wdata_c;
    logic                        unused_c;

    assign req_c    = MEMORY_HANDSHAKE_UNIT_RD_In | MEMORY_HANDSHAKE_UNIT_WRMain_In;
    // A simultaneous RD and WRMain resolves to a read.
    assign op_in_c  = MEMORY_HANDSHAKE_UNIT_RD_In ? OP_READ : OP_WRITE;
    assign idx_in_c = MEMORY_HANDSHAKE_UNIT_A_InBus[ADDR_INDEX_BITS+1:2];

    // With zero wait states the RAM is accessed on the accepting edge, straight from the inputs.
    assign direct_c = (state_q == IDLE) && req_c && (WAIT_STATES == 0);
    assign finish_c = (state_q == WAIT) && (cnt_q == WAIT_CNT_WIDTH'(1));

`ifdef MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN
    logic mis_lat_q;
    logic mis_out_q;
    logic mis_in_c;

    assign mis_in_c = (MEMORY_HANDSHAKE_UNIT_A_InBus[1:0] != 2'b00);
    assign trap_c   = direct_c ? mis_in_c : mis_lat_q;
    assign unused_c = ^MEMORY_HANDSHAKE_UNIT_A_InBus[DATAWIDTH_BUS-1:ADDR_INDEX_BITS+2];
    assign MEMORY_HANDSHAKE_UNIT_Misalign_Out = mis_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_lat_q <= 1'b0;
            mis_out_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && req_c) begin
                mis_lat_q <= mis_in_c;
            end
            mis_out_q <= (direct_c || finish_c) && trap_c;
        end
    end
`else
    assign trap_c   = 1'b0;
    assign unused_c = ^{MEMORY_HANDSHAKE_UNIT_A_InBus[DATAWIDTH_BUS-1:ADDR_INDEX_BITS+2],
                        MEMORY_HANDSHAKE_UNIT_A_InBus[1:0]};
`endif

    // Reset is folded in so a request coincident with reset cannot write the array.
    assign ram_en_c    = (direct_c || finish_c) && !trap_c && !rst;
    assign ram_we_c    = direct_c ? (op_in_c == OP_WRITE) : (op_q == OP_WRITE);
    assign ram_addr_c  = direct_c ? idx_in_c : idx_q;
    assign ram_wdata_c = direct_c ? MEMORY_HANDSHAKE_UNIT_B_InBus : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (req_c) begin
                        idx_q   <= idx_in_c;
                        wdata_q <= MEMORY_HANDSHAKE_UNIT_B_InBus;
                        op_q    <= op_in_c;
                        cnt_q   <= WAIT_CNT_WIDTH'(WAIT_STATES);
                        busy_q  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - WAIT_CNT_WIDTH'(1);
                    if (cnt_q == WAIT_CNT_WIDTH'(1)) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    memory_handshake_ram #(
        .DATA_W (DATAWIDTH_BUS),
        .ADDR_W (ADDR_INDEX_BITS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ram_en_c),
        .we_i    (ram_we_c),
        .addr_i  (ram_addr_c),
        .wdata_i (ram_wdata_c),
        .rdata_o (MEMORY_HANDSHAKE_UNIT_Data_OutBus)
    );

    assign MEMORY_HANDSHAKE_UNIT_ACK_Out  = ack_q;
    assign MEMORY_HANDSHAKE_UNIT_Busy_Out = busy_q;

endmodule

// File: tb/tb_memory_handshake_unit.sv
// Directed bench: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance sharing clock and reset.
module tb_memory_handshake_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic        a_rd = 1'b0, a_wr = 1'b0, a_ack, a_busy;
    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic        b_rd = 1'b0, b_wr = 1'b0, b_ack, b_busy;
`ifdef MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN
    logic        a_mis, b_mis;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    memory_handshake_unit #(.WAIT_STATES(2)) dut_a (
        .MEMORY_HANDSHAKE_UNIT_CLOCK_50      (clk),
        .MEMORY_HANDSHAKE_UNIT_ResetInHigh_In(rst),
        .MEMORY_HANDSHAKE_UNIT_A_InBus       (a_addr),
        .MEMORY_HANDSHAKE_UNIT_B_InBus       (a_wdata),
        .MEMORY_HANDSHAKE_UNIT_RD_In         (a_rd),
        .MEMORY_HANDSHAKE_UNIT_WRMain_In     (a_wr),
        .MEMORY_HANDSHAKE_UNIT_Data_OutBus   (a_rdata),
        .MEMORY_HANDSHAKE_UNIT_ACK_Out       (a_ack),
        .MEMORY_HANDSHAKE_UNIT_Busy_Out      (a_busy)
`ifdef MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN
        ,
        .MEMORY_HANDSHAKE_UNIT_Misalign_Out  (a_mis)
`endif
    );

    memory_handshake_unit #(.WAIT_STATES(0)) dut_b (
        .MEMORY_HANDSHAKE_UNIT_CLOCK_50      (clk),
        .MEMORY_HANDSHAKE_UNIT_ResetInHigh_In(rst),
        .MEMORY_HANDSHAKE_UNIT_A_InBus       (b_addr),
        .MEMORY_HANDSHAKE_UNIT_B_InBus       (b_wdata),
        .MEMORY_HANDSHAKE_UNIT_RD_In         (b_rd),
        .MEMORY_HANDSHAKE_UNIT_WRMain_In     (b_wr),
        .MEMORY_HANDSHAKE_UNIT_Data_OutBus   (b_rdata),
        .MEMORY_HANDSHAKE_UNIT_ACK_Out       (b_ack),
        .MEMORY_HANDSHAKE_UNIT_Busy_Out      (b_busy)
`ifdef MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN
        ,
        .MEMORY_HANDSHAKE_UNIT_Misalign_Out  (b_mis)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One WAIT_STATES=2 transaction: ACK must appear on the third edge after acceptance, one cycle wide.
    // Bus inputs are scrambled during WAIT to confirm the latched values are used.
    task automatic txn_a(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data, input logic exp_mis);
        @(negedge clk);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data;
        @(posedge clk); #1;
        chk({tag, "_acc_ack"}, 32'(a_ack), 32'd0);
        chk({tag, "_acc_busy"}, 32'(a_busy), 32'd1);
        a_addr = ~addr; a_wdata = ~data;
        @(posedge clk); #1;
        chk({tag, "_wait_ack"}, 32'(a_ack), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_resp_ack"}, 32'(a_ack), 32'd1);
        chk({tag, "_resp_busy"}, 32'(a_busy), 32'd1);
`ifdef MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN
        chk({tag, "_mis"}, 32'(a_mis), 32'(exp_mis));
`else
        if (exp_mis) $display("[TB] %s: misalign trap not built, A[1:0] ignored", tag);
`endif
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_post_ack"}, 32'(a_ack), 32'd0);
        chk({tag, "_post_busy"}, 32'(a_busy), 32'd0);
    endtask

    initial begin
        // Outputs during and after power-on reset
        #2;
        chk("rst_a_data", a_rdata, 32'h0);
        chk("rst_a_ack",  32'(a_ack),  32'd0);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_b_data", b_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Prime 0x10, then reset in the middle of a write's WAIT phase
        txn_a("w10", 1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0);
        @(negedge clk);
        a_wr = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("abort_busy_pre", 32'(a_busy), 32'd1);
        @(negedge clk);
        rst = 1'b1; a_wr = 1'b0;
        #1;
        chk("abort_rst_data", a_rdata, 32'h0);
        chk("abort_rst_ack",  32'(a_ack),  32'd0);
        chk("abort_rst_busy", 32'(a_busy), 32'd0);
        @(posedge clk); #1;
        chk("abort_rst_ack2", 32'(a_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_ack", 32'(a_ack), 32'd0);
        end
        txn_a("r10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("abort_prior_data", a_rdata, 32'h1111_1111);

        // Write then read 0x40; data bus must hold across the write
        txn_a("w40", 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b0);
        chk("w40_hold", a_rdata, 32'h1111_1111);
        txn_a("r40", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("r40_data", a_rdata, 32'hCAFE_F00D);

        // RD and WRMain together resolve to a read
        txn_a("w80", 1'b0, 1'b1, 32'h80, 32'h55AA_55AA, 1'b0);
        txn_a("rw80", 1'b1, 1'b1, 32'h80, 32'h1234_5678, 1'b0);
        chk("rw80_data", a_rdata, 32'h55AA_55AA);
        txn_a("r80", 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
        chk("r80_unchanged", a_rdata, 32'h55AA_55AA);

        // Upper address bits alias onto the 1024-word array
        txn_a("w1004", 1'b0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 1'b0);
        txn_a("r4", 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
        chk("alias_data", a_rdata, 32'hA5A5_A5A5);

        // Misaligned write to 0x42
        txn_a("w42", 1'b0, 1'b1, 32'h0000_0042, 32'h7777_7777, 1'b1);
        txn_a("r40b", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
`ifdef MEMORY_HANDSHAKE_UNIT_MISALIGN_TRAP_EN
        chk("mis_ram_kept", a_rdata, 32'hCAFE_F00D);
`else
        chk("mis_ram_written", a_rdata, 32'h7777_7777);
`endif

        // Zero wait states: single write, then RD held continuously
        @(negedge clk);
        b_wr = 1'b1; b_addr = 32'h8; b_wdata = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        chk("b_w_ack",  32'(b_ack),  32'd1);
        chk("b_w_busy", 32'(b_busy), 32'd1);
        @(negedge clk);
        b_wr = 1'b0;
        @(posedge clk); #1;
        chk("b_w_idle_ack", 32'(b_ack), 32'd0);
        @(negedge clk);
        b_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b_hold_ack1",  32'(b_ack),  32'd1);
            chk("b_hold_busy1", 32'(b_busy), 32'd1);
            chk("b_hold_data1", b_rdata, 32'h9ABC_DEF0);
            @(posedge clk); #1;
            chk("b_hold_ack0",  32'(b_ack),  32'd0);
            chk("b_hold_busy0", 32'(b_busy), 32'd0);
            chk("b_hold_data0", b_rdata, 32'h9ABC_DEF0);
        end
        @(negedge clk);
        b_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("b_final_ack", 32'(b_ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
